lf_wide_add_seq: RTL and testbench
==================================

Name: lf_wide_add_seq

Overview:
- Multi-cycle sequencer that performs WORDS×32-bit add/subtract by time-multiplexing one 32-bit Ladner-Fischer adder core.
- Processes one 32-bit word per cycle, LSW first, with the carry chained through a register between words.
- Sits between the operand source and the result consumer, with valid/ready handshakes on both sides.
- Is the sole owner and scheduler of its adder core instance.

Parameters:
- WORDS, 4, number of 32-bit words per operand (legal range 2..16); the full operand width is 32*WORDS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  sequencer can accept a request
- in_a  input  32*WORDS  operand A
- in_b  input  32*WORDS  operand B
- in_cin  input  1  carry-in for add mode
- in_sub  input  1  1 = compute A−B (B inverted, carry-in forced to 1, in_cin ignored)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  32*WORDS  result
- out_cout  output  1  carry out of the MSB; in subtract mode, 1 means no borrow
- out_ovf  output  1  two's-complement signed overflow of the full-width operation

Behaviour:
- Interface timing: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, word counter=0, carry reg=0, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A, B' (B' = in_sub ? ~in_b : in_b), and carry reg = in_sub ? 1 : in_cin.
  - Clear the counter and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, word k = counter: sum_k = A[k] + B'[k] + carry, written into out_sum[32k+:32].
  - carry reg ← cout_k; counter increments.
  - When k = WORDS−1, also capture out_cout = cout_k and out_ovf = (A_msb == B'_msb) && (sum_msb != A_msb), then go to DONE.
  - RUN lasts exactly WORDS cycles.
- DONE:
  - out_valid=1.
  - out_sum, out_cout and out_ovf are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. out_valid drops the next cycle and in_ready rises the next cycle.
- Latency: the accept edge is cycle 0 and out_valid is high in cycle WORDS+1.
- Throughput: one operation per WORDS+2 cycles when out_ready is held high.
- out_sum words are updated progressively during RUN. Consumers must sample only while out_valid=1.
- in_valid asserted outside IDLE has no effect. Requests are not queued and latched operands are unaffected.
- in_a/in_b/in_cin/in_sub may change freely after acceptance.
- Reset mid-operation discards the operation, returns all outputs to their reset values immediately (asynchronously), and no result is ever presented.
- Carry wrap: the carry out of the final word is never fed into the next operation. Each accept reloads the carry reg.
- Counter width is $clog2(WORDS). The counter never exceeds WORDS−1.

Decomposition:
- Package lf_pkg:
  - LF_WORD_W = 32.
  - State enum typedef lf_seq_state_t {IDLE, RUN, DONE}.
  - Word typedef lf_word_t (logic [31:0]).
- Sub-module lf_add_core32: purely combinational 32-bit Ladner-Fischer adder (a, b, cin → sum, cout). It is built from the existing level0 p/g generation and prefix levels and is instantiated once here.
- Operand registers and the word select (indexed part-select on the counter) stay in the sequencer.

Test Plan:
- WORDS=4, add, A=all ones (128'hFFFF…F), B=1, cin=0 → out_sum=0, out_cout=1, out_ovf=0; out_valid first high exactly 5 cycles after the accept edge.
- Subtract, A=0, B=1 → out_sum=128'hFFFF…F, out_cout=0 (borrow), out_ovf=0. Then A=5, B=3 → out_sum=2, out_cout=1.
- Signed overflow: A=128'h7FFF…F, B=1, add → out_sum=128'h8000…0, out_ovf=1, out_cout=0. Also A=128'h8000…0 minus 1 → out_sum=128'h7FFF…F, out_ovf=1.
- Carry across a word boundary: A=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1 → out_sum=128'h0000_0001_0000_0000_0000_0000_0000_0000.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_sum/out_cout/out_ovf stable, in_ready=0, in_valid pulses ignored. Release → IDLE next cycle and the next request completes correctly.
- Reset mid-RUN (rst_n low at cycle 2 after accept) → out_valid=0, in_ready=1 immediately. After release, A=3, B=4 add → out_sum=7, with no stale carry or partial words.

Source files
------------

// File: rtl/lf_wide_add_seq_pkg.sv
// Shared types for the wide add/sub sequencer.
// Word width, word type and sequencer states.
package lf_pkg;
  localparam int LF_WORD_W = 32;

  typedef logic [LF_WORD_W-1:0] lf_word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } lf_seq_state_t;
endpackage

// File: rtl/lf_wide_add_seq_if.sv
// Operand/result handshake bundle.
// Source and consumer sides share one interface.
interface lf_wide_add_seq_if
  import lf_pkg::*;
#(
  parameter int WORDS = 4
) ();
  localparam int W = LF_WORD_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b,
    output in_cin, in_sub, out_ready,
    input  in_ready, out_valid,
    input  out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b,
    input  in_cin, in_sub, out_ready,
    output in_ready, out_valid,
    output out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/lf_wide_add_seq_core.sv
// Combinational 32-bit Ladner-Fischer adder.
// Level-0 p/g, five prefix levels, carry-in folded last.
module lf_add_core32
  import lf_pkg::*;
(
  input  lf_word_t a,
  input  lf_word_t b,
  input  logic     cin,
  output lf_word_t sum,
  output logic     cout
);
  lf_word_t g0, p0, gp, pp, c;

  // level 0 generate/propagate
  assign g0 = a & b;
  assign p0 = a ^ b;

  for (genvar l = 0; l < 5; l++) begin : lvl
    lf_word_t gi, pi, go, po;
    if (l == 0) begin : g_first
      assign gi = g0;
      assign pi = p0;
    end else begin : g_next
      assign gi = lvl[l-1].go;
      assign pi = lvl[l-1].po;
    end
    for (genvar i = 0; i < 32; i++) begin : bt
      if (((i >> l) & 1) == 1) begin : g_cmb
        localparam int J = ((i >> l) << l) - 1;
        assign go[i] = gi[i] | (pi[i] & gi[J]);
        assign po[i] = pi[i] & pi[J];
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  assign gp = lvl[4].go;
  assign pp = lvl[4].po;

  // gp/pp[i] span bits 0..i, so carry-in is applied once here
  assign c    = {gp[30:0] | (pp[30:0] & {31{cin}}), cin};
  assign sum  = p0 ^ c;
  assign cout = gp[31] | (pp[31] & cin);
endmodule

// File: rtl/lf_wide_add_seq.sv
// WORDS x 32-bit add/sub, one word per cycle, LSW first.
// One shared adder core; carry chained through carry_q.
module lf_wide_add_seq
  import lf_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  lf_wide_add_seq_if.slave   bus
);
  localparam int W  = LF_WORD_W * WORDS;
  localparam int CW = $clog2(WORDS);

  typedef logic [CW-1:0] cnt_t;

  lf_seq_state_t state, state_nx;

  logic [W-1:0] a_q, b_q, sum_q;
  logic         carry_q, cout_q, ovf_q;
  cnt_t         cnt_q;

  logic     accept, last, cw;
  lf_word_t aw, bw, sw;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (cnt_q == cnt_t'(WORDS - 1));

  assign aw = a_q[cnt_q*LF_WORD_W +: LF_WORD_W];
  assign bw = b_q[cnt_q*LF_WORD_W +: LF_WORD_W];

  lf_add_core32 u_core (
    .a    (aw),
    .b    (bw),
    .cin  (carry_q),
    .sum  (sw),
    .cout (cw)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: IDLE -> RUN (WORDS cycles) -> DONE -> IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, per-word accumulate, final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.in_a;
      b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
      carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      sum_q[cnt_q*LF_WORD_W +: LF_WORD_W] <= sw;
      carry_q <= cw;
      if (last) begin
        cout_q <= cw;
        ovf_q  <= (aw[31] == bw[31]) && (sw[31] != aw[31]);
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_lf_wide_add_seq.sv
// Bench for lf_wide_add_seq: directed ops into a
// scoreboard queue, monitor pops on out_valid&&out_ready.
module tb_lf_wide_add_seq;
  import lf_pkg::*;

  localparam int WORDS = 4;
  localparam int W     = LF_WORD_W * WORDS;

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ONE  = W'(1);

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  exp_t mon_e;

  lf_wide_add_seq_if #(.WORDS(WORDS)) bus ();

  lf_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %h want none",
                 bus.out_sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_sum", bus.out_sum, mon_e.sum);
        chk("out_cout", W'(bus.out_cout), W'(mon_e.cout));
        chk("out_ovf", W'(bus.out_ovf), W'(mon_e.ovf));
      end
    end
  end

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b,
                       logic cin, logic sub,
                       logic [W-1:0] es, logic ec, logic eo);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", W'(bus.in_ready), W'(1));
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    e.sum  = es;
    e.cout = ec;
    e.ovf  = eo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    bus.in_cin   = ~cin;
  endtask

  // accept sampled in cycle 0; valid expected in cycle WORDS+1
  task automatic wait_valid();
    int edges;
    edges = 0;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("latency_cycle", W'(edges + 1), W'(WORDS + 1));
  endtask

  task automatic complete();
    @(posedge clk);
    #1;
    chk("out_valid_drop", W'(bus.out_valid), W'(0));
    chk("in_ready_rise", W'(bus.in_ready), W'(1));
  endtask

  task automatic op(logic [W-1:0] a, logic [W-1:0] b,
                    logic cin, logic sub,
                    logic [W-1:0] es, logic ec, logic eo);
    issue(a, b, cin, sub, es, ec, eo);
    wait_valid();
    complete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_sum", bus.out_sum, '0);
    chk("rst_out_cout", W'(bus.out_cout), W'(0));
    chk("rst_out_ovf", W'(bus.out_ovf), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    op(ONES, ONE, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    op('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    op('0, ONE, 1'b0, 1'b1, ONES, 1'b0, 1'b0);
    op(W'(5), W'(3), 1'b0, 1'b1, W'(2), 1'b1, 1'b0);
    op(MAXP, ONE, 1'b0, 1'b0, MSB, 1'b0, 1'b1);
    op(MSB, ONE, 1'b0, 1'b1, MAXP, 1'b1, 1'b1);
    op({32'h0, {96{1'b1}}}, ONE, 1'b0, 1'b0,
       {32'h1, 96'h0}, 1'b0, 1'b0);
    op(W'(10), W'(20), 1'b1, 1'b0, W'(31), 1'b0, 1'b0);

    // backpressure: hold result three cycles, poke in_valid
    bus.out_ready = 1'b0;
    issue(W'(32'h1234_5678), W'(32'h1111_1111), 1'b0, 1'b0,
          W'(32'h2345_6789), 1'b0, 1'b0);
    wait_valid();
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = ONES;
      bus.in_b     = ONES;
      chk("bp_out_valid", W'(bus.out_valid), W'(1));
      chk("bp_in_ready", W'(bus.in_ready), W'(0));
      chk("bp_out_sum", bus.out_sum, W'(32'h2345_6789));
      chk("bp_out_cout", W'(bus.out_cout), W'(0));
      chk("bp_out_ovf", W'(bus.out_ovf), W'(0));
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    complete();
    op(W'(100), W'(50), 1'b1, 1'b1, W'(50), 1'b1, 1'b0);

    // reset two cycles into RUN discards the operation
    issue(ONES, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    chk("mid_rst_out_valid", W'(bus.out_valid), W'(0));
    chk("mid_rst_in_ready", W'(bus.in_ready), W'(1));
    chk("mid_rst_out_sum", bus.out_sum, '0);
    chk("mid_rst_out_cout", W'(bus.out_cout), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    op(W'(3), W'(4), 1'b0, 1'b0, W'(7), 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
